// File: rtl/sprite_line_evaluator.sv
// Sprite line evaluator: during h-blank, scans the object table for the next line and builds a slot list of up to MAX_SLOTS sprites.
// Latency: launch at hcount==EVAL_START, DONE is reached MAX_OBJECTS+2 clks later; the list becomes visible the clk after hcount wraps to 0.
// Backpressure: none; an evaluation still running at the swap is aborted and flagged via eval_late. Optional macro: SPRITE_LINE_EVAL_STATS_EN.
module sprite_line_evaluator #(
  parameter int MAX_OBJECTS   = 100,
  parameter int MAX_SLOTS     = 8,
  parameter int SPRITE_HEIGHT = 32,
  parameter int EVAL_START    = 1280,
  parameter int V_TOTAL       = 525
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [10:0]             hcount,
  input  logic [9:0]              vcount,
  output logic [6:0]              obj_rd_idx,
  input  logic [29:0]             obj_rd_data,
  output logic [MAX_SLOTS-1:0]    slot_valid,
  output logic [MAX_SLOTS*12-1:0] slot_x,
  output logic [MAX_SLOTS*5-1:0]  slot_row,
  output logic [MAX_SLOTS*5-1:0]  slot_sprite,
  output logic [3:0]              slot_count,
  output logic                    line_ovf,
  output logic                    eval_late
`ifdef SPRITE_LINE_EVAL_STATS_EN
  ,
  output logic [7:0]              ovf_lines
`endif
);

  localparam int SLOTW = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;
  localparam logic [3:0] SLOTS4 = 4'(MAX_SLOTS);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t state, state_nxt;
  logic [10:0] hcount_q;
  logic [9:0]  next_line;
  logic        data_vld;
  logic        launch, swap, scanning, hit;
  logic [12:0] obj_y13, line13, y_end, row_diff;

  // back bank (being built) and front bank (driving outputs)
  logic [MAX_SLOTS-1:0][11:0] back_x, front_x;
  logic [MAX_SLOTS-1:0][4:0]  back_row, front_row;
  logic [MAX_SLOTS-1:0][4:0]  back_spr, front_spr;
  logic [MAX_SLOTS-1:0]       back_valid;
  logic [3:0]                 back_count;
  logic                       back_ovf;

  assign launch   = (hcount == 11'(EVAL_START));
  assign swap     = (hcount == 11'd0) && (hcount_q != 11'd0);
  assign scanning = (state == SCAN) || (state == DRAIN);

  assign slot_x      = front_x;
  assign slot_row    = front_row;
  assign slot_sprite = front_spr;

  // hit test in 13-bit unsigned math so y+SPRITE_HEIGHT never wraps
  always_comb begin
    obj_y13  = {1'b0, obj_rd_data[17:6]};
    line13   = {3'b000, next_line};
    y_end    = obj_y13 + 13'(SPRITE_HEIGHT);
    row_diff = line13 - obj_y13;
    hit      = data_vld && scanning && obj_rd_data[0] &&
               (line13 >= obj_y13) && (line13 < y_end);
  end

  // next-state logic; the line swap always wins and aborts any evaluation
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = SCAN;
      SCAN:    if (obj_rd_idx == 7'd0) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (swap) state_nxt = IDLE;
  end

  // state register, hcount edge detector, read index and read-data pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hcount_q   <= 11'd0;
      obj_rd_idx <= 7'd0;
      next_line  <= 10'd0;
      data_vld   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hcount_q <= hcount;
      data_vld <= (state == SCAN) && !swap;
      if (swap) begin
        obj_rd_idx <= 7'd0;
      end else if (state == IDLE && launch) begin
        obj_rd_idx <= 7'(MAX_OBJECTS - 1);
        next_line  <= (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
      end else if (state == SCAN && obj_rd_idx != 7'd0) begin
        obj_rd_idx <= obj_rd_idx - 7'd1;
      end
    end
  end

  // back bank: cleared at launch, filled in scan order (highest index first)
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE && launch)) begin
      back_x     <= '0;
      back_row   <= '0;
      back_spr   <= '0;
      back_valid <= '0;
      back_count <= 4'd0;
      back_ovf   <= 1'b0;
    end else if (hit && !swap) begin
      if (back_count < SLOTS4) begin
        back_x[back_count[SLOTW-1:0]]     <= obj_rd_data[29:18];
        back_row[back_count[SLOTW-1:0]]   <= row_diff[4:0];
        back_spr[back_count[SLOTW-1:0]]   <= obj_rd_data[5:1];
        back_valid[back_count[SLOTW-1:0]] <= 1'b1;
        back_count                        <= back_count + 4'd1;
      end else begin
        back_ovf <= 1'b1;
      end
    end
  end

  // front bank: only changes at the swap, so it is stable for a whole line
  always_ff @(posedge clk) begin
    if (reset) begin
      front_x    <= '0;
      front_row  <= '0;
      front_spr  <= '0;
      slot_valid <= '0;
      slot_count <= 4'd0;
      line_ovf   <= 1'b0;
      eval_late  <= 1'b0;
    end else if (swap) begin
      if (state == DONE) begin
        front_x    <= back_x;
        front_row  <= back_row;
        front_spr  <= back_spr;
        slot_valid <= back_valid;
        slot_count <= back_count;
        line_ovf   <= back_ovf;
        eval_late  <= 1'b0;
      end else begin
        front_x    <= '0;
        front_row  <= '0;
        front_spr  <= '0;
        slot_valid <= '0;
        slot_count <= 4'd0;
        line_ovf   <= 1'b0;
        eval_late  <= scanning;
      end
    end
  end

`ifdef SPRITE_LINE_EVAL_STATS_EN
  logic new_ovf;
  assign new_ovf = (state == DONE) && back_ovf;

  // per-frame saturating count of overflowed lines; restarts when line 0 is shown
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_lines <= 8'd0;
    end else if (swap) begin
      if (vcount == 10'd0)
        ovf_lines <= {7'd0, new_ovf};
      else if (new_ovf && ovf_lines != 8'hFF)
        ovf_lines <= ovf_lines + 8'd1;
    end
  end
`endif

endmodule
